// File: rtl/clk_activity_arbiter.sv
// clk_activity_arbiter
//   Clock-presence detector and BUFGMUX source arbiter running entirely on the
//   local 10 MHz reference. Each monitored domain supplies a slow toggle bit;
//   every channel is qualified by counting edges over a fixed window with
//   acquire/loss hysteresis. The lowest-index live channel (or a forced index)
//   is selected through a mute-bracketed switch sequence.
//
// Ports
//   clk10        in   reference clock, the only clock
//   rst_n        in   asynchronous active-low reset
//   tog_in       in   [N_CH]  per-channel toggle bits, asynchronous to clk10
//   force_en     in   manual override enable
//   force_sel    in   [SEL_W] manual override index
//   sel          out  [SEL_W] registered BUFGMUX select index
//   active       out  [N_CH]  registered qualified-alive flags
//   mute         out  high across the whole switch sequence
//   switch_pulse out  one-cycle strobe in the cycle sel changes
module clk_activity_arbiter #(
  parameter int N_CH      = 2,
  parameter int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int WIN_LOG2  = 24,
  parameter int EDGE_W    = 8,
  parameter int MIN_EDGES = 4,
  parameter int ACQ_WIN   = 2,
  parameter int LOSS_WIN  = 1,
  parameter int FALLBACK  = 0,
  parameter int MUTE_CYC  = 16
) (
  input  logic             clk10,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  tog_in,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  active,
  output logic             mute,
  output logic             switch_pulse
);

  localparam int PS_W = $clog2(ACQ_WIN + 1);
  localparam int FS_W = $clog2(LOSS_WIN + 1);
  localparam int TM_W = (MUTE_CYC > 1) ? $clog2(MUTE_CYC) : 1;
  localparam logic [SEL_W-1:0] FB_SEL = SEL_W'(FALLBACK);
  localparam logic [TM_W-1:0]  TM_MAX = TM_W'(MUTE_CYC - 1);

  // Synchroniser plus history flop; edge_det fires on either transition.
  logic [N_CH-1:0] sync1_q, sync2_q, hist_q, edge_det;

  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= tog_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ hist_q;

  // Free-running observation window.
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic                win_end;

  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) win_cnt_q <= '0;
    else        win_cnt_q <= win_cnt_q + 1'b1;
  end

  assign win_end = &win_cnt_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [EDGE_W-1:0] cnt_q;
    logic [EDGE_W:0]   cnt_incl;
    logic              pass;
    logic [PS_W-1:0]   pstk_q, pstk_nxt;
    logic [FS_W-1:0]   fstk_q, fstk_nxt;
    logic              act_q;

    // The window-end cycle's own edge counts toward the closing window here
    // and also seeds the next window through the reload below.
    always_comb begin
      cnt_incl = {1'b0, cnt_q} + {{EDGE_W{1'b0}}, edge_det[g]};
      pass     = (cnt_incl >= (EDGE_W + 1)'(MIN_EDGES));
      pstk_nxt = '0;
      fstk_nxt = '0;
      if (pass) pstk_nxt = (pstk_q == PS_W'(ACQ_WIN))  ? pstk_q : pstk_q + 1'b1;
      else      fstk_nxt = (fstk_q == FS_W'(LOSS_WIN)) ? fstk_q : fstk_q + 1'b1;
    end

    always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        pstk_q <= '0;
        fstk_q <= '0;
        act_q  <= 1'b0;
      end else if (win_end) begin
        cnt_q  <= EDGE_W'(edge_det[g]);
        pstk_q <= pstk_nxt;
        fstk_q <= fstk_nxt;
        if (!act_q && pstk_nxt == PS_W'(ACQ_WIN))
          act_q <= 1'b1;
        else if (act_q && fstk_nxt == FS_W'(LOSS_WIN))
          act_q <= 1'b0;
      end else if (edge_det[g] && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign active[g] = act_q;
  end

  // Selection target: forced index if valid, else lowest live channel.
  logic [SEL_W-1:0] target;
  logic             found;

  always_comb begin
    target = FB_SEL;
    found  = 1'b0;
    if (force_en) begin
      target = (int'(force_sel) >= N_CH) ? FB_SEL : force_sel;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (active[i] && !found) begin
          target = SEL_W'(i);
          found  = 1'b1;
        end
      end
    end
  end

  // Switch sequencer.
  typedef enum logic [1:0] {IDLE, PRE, POST} state_t;

  state_t           state_q, state_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic [SEL_W-1:0] lat_q, lat_d, sel_d;
  logic             mute_d, pulse_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lat_d   = lat_q;
    sel_d   = sel;
    mute_d  = mute;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (target != sel) begin
          lat_d   = target;
          mute_d  = 1'b1;
          timer_d = TM_MAX;
          state_d = PRE;
        end
      end
      PRE: begin
        if (timer_q == '0) begin
          sel_d   = lat_q;
          pulse_d = 1'b1;
          timer_d = TM_MAX;
          state_d = POST;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      POST: begin
        if (timer_q == '0) begin
          mute_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      lat_q        <= '0;
      sel          <= FB_SEL;
      mute         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lat_q        <= lat_d;
      sel          <= sel_d;
      mute         <= mute_d;
      switch_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_clk_activity_arbiter.sv
// Testbench for clk_activity_arbiter (N_CH=3, WIN_LOG2=4, MIN_EDGES=2,
// ACQ_WIN=2, LOSS_WIN=1, MUTE_CYC=4, FALLBACK=0). Directed stimulus pushes
// cycle-stamped expectations into a scoreboard queue; a negedge monitor pops
// and compares them when the bench cycle count reaches each stamp.
module tb_clk_activity_arbiter;

  logic       clk10 = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tog_in = 3'b101;
  logic       force_en = 1'b0;
  logic [1:0] force_sel = 2'd0;
  logic [1:0] sel;
  logic [2:0] active;
  logic       mute;
  logic       switch_pulse;

  clk_activity_arbiter #(
    .N_CH(3), .SEL_W(2), .WIN_LOG2(4), .EDGE_W(8), .MIN_EDGES(2),
    .ACQ_WIN(2), .LOSS_WIN(1), .FALLBACK(0), .MUTE_CYC(4)
  ) dut (
    .clk10(clk10), .rst_n(rst_n), .tog_in(tog_in), .force_en(force_en),
    .force_sel(force_sel), .sel(sel), .active(active), .mute(mute),
    .switch_pulse(switch_pulse)
  );

  always #5 clk10 = ~clk10;

  int cyc = 0;
  always @(posedge clk10) cyc <= cyc + 1;

  typedef struct packed {
    logic [95:0] tag;
    int          cyc;
    logic [3:0]  m;   // check mask: sel, active, mute, pulse
    logic [1:0]  s;
    logic [2:0]  a;
    logic        mu;
    logic        p;
  } exp_t;

  localparam logic [3:0] M_ALL = 4'hF, M_S = 4'h8, M_A = 4'h4, M_M = 4'h2, M_P = 4'h1;

  exp_t sbq[$];
  exp_t ce;
  int   checks = 0;
  int   errors = 0;
  int   drain_left = 64;
  logic fin_req = 1'b0;
  logic mon_done = 1'b0;

  int         gph = 0;
  int         base = 0;
  logic [2:0] en_per = 3'b000;
  logic       en_sgl = 1'b0;

  task automatic expect_at(input logic [95:0] tag, input int rel, input logic [3:0] m,
                           input logic [1:0] s, input logic [2:0] a,
                           input logic mu, input logic p);
    exp_t e;
    int   i;
    e.tag = tag; e.cyc = base + rel; e.m = m; e.s = s; e.a = a; e.mu = mu; e.p = p;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > e.cyc) i--;
    sbq.insert(i, e);
  endtask

  // One clock: period-3 toggles on en_per channels, single toggle per
  // 16-cycle window on channel 2 (lands mid-window) when en_sgl is set.
  task automatic step_one();
    logic [2:0] msk;
    @(posedge clk10);
    #1;
    gph++;
    msk = 3'b000;
    if (gph % 3 == 0) msk = en_per;
    if (en_sgl && (gph % 16 == 5)) msk[2] = ~msk[2];
    tog_in = tog_in ^ msk;
  endtask

  task automatic step_to(input int n);
    while (gph < n) step_one();
  endtask

  task automatic do_release();
    rst_n  = 1'b1;
    tog_in = 3'b010;
    gph    = 0;
    base   = cyc;
  endtask

  always @(negedge clk10) begin
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      ce = sbq.pop_front();
      if (ce.m[3]) begin
        checks++;
        assert (sel === ce.s) else begin
          errors++;
          $error("FAIL %0s: sel=%0d expected %0d (cycle %0d)", ce.tag, sel, ce.s, ce.cyc);
        end
      end
      if (ce.m[2]) begin
        checks++;
        assert (active === ce.a) else begin
          errors++;
          $error("FAIL %0s: active=%b expected %b (cycle %0d)", ce.tag, active, ce.a, ce.cyc);
        end
      end
      if (ce.m[1]) begin
        checks++;
        assert (mute === ce.mu) else begin
          errors++;
          $error("FAIL %0s: mute=%b expected %b (cycle %0d)", ce.tag, mute, ce.mu, ce.cyc);
        end
      end
      if (ce.m[0]) begin
        checks++;
        assert (switch_pulse === ce.p) else begin
          errors++;
          $error("FAIL %0s: switch_pulse=%b expected %b (cycle %0d)", ce.tag, switch_pulse, ce.p, ce.cyc);
        end
      end
    end
    if (fin_req && !mon_done) begin
      if (sbq.size() == 0) begin
        mon_done = 1'b1;
      end else if (drain_left == 0) begin
        checks++;
        assert (sbq.size() == 0) else begin
          errors++;
          $error("FAIL drain: %0d expectations still pending, expected 0", sbq.size());
        end
        mon_done = 1'b1;
      end else begin
        drain_left--;
      end
    end
  end

  initial begin
    // Reset held with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk10);
      #1;
      tog_in = ~tog_in;
      expect_at("rst_hold", cyc, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    end
    @(posedge clk10);
    #1;
    tog_in = 3'b000;
    expect_at("rst_hold", cyc, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);

    // Acquire channel 1; channel 2 gets exactly one edge per window.
    do_release();
    en_per = 3'b010;
    en_sgl = 1'b1;
    expect_at("acq_w1",     16, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("acq_pre",    31, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("acq_act",    32, M_ALL, 2'd0, 3'b010, 1'b0, 1'b0);
    expect_at("acq_mute",   33, M_ALL, 2'd0, 3'b010, 1'b1, 1'b0);
    expect_at("acq_hold",   36, M_S | M_M | M_P, 2'd0, 3'b000, 1'b1, 1'b0);
    expect_at("acq_sw",     37, M_S | M_M | M_P, 2'd1, 3'b000, 1'b1, 1'b1);
    expect_at("acq_post",   38, M_S | M_M | M_P, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("acq_post",   40, M_M, 2'd0, 3'b000, 1'b1, 1'b0);
    expect_at("acq_unmute", 41, M_ALL, 2'd1, 3'b010, 1'b0, 1'b0);
    step_to(41);

    // Loss of channel 1.
    en_per = 3'b000;
    expect_at("loss_pre",   63, M_S | M_A | M_M, 2'd1, 3'b010, 1'b0, 1'b0);
    expect_at("loss_act",   64, M_S | M_A | M_M, 2'd1, 3'b000, 1'b0, 1'b0);
    expect_at("loss_mute",  65, M_S | M_M, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("loss_hold",  68, M_S | M_M, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("loss_sw",    69, M_S | M_M | M_P, 2'd0, 3'b000, 1'b1, 1'b1);
    expect_at("loss_post",  72, M_S | M_M | M_P, 2'd0, 3'b000, 1'b1, 1'b0);
    expect_at("loss_unmute", 73, M_S | M_M, 2'd0, 3'b000, 1'b0, 1'b0);
    step_to(80);

    // Priority: channels 1 and 2 both live.
    expect_at("single_edge", 80, M_A, 2'd0, 3'b000, 1'b0, 1'b0);
    en_sgl = 1'b0;
    en_per = 3'b110;
    expect_at("prio_w1",    96, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("prio_pre",  111, M_A, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("prio_act",  112, M_ALL, 2'd0, 3'b110, 1'b0, 1'b0);
    expect_at("prio_mute", 113, M_S | M_M, 2'd0, 3'b000, 1'b1, 1'b0);
    expect_at("prio_sw",   117, M_S | M_P, 2'd1, 3'b000, 1'b1, 1'b1);
    expect_at("prio_end",  121, M_S | M_M, 2'd1, 3'b000, 1'b0, 1'b0);
    step_to(121);

    // Kill channel 1: direct move 1 -> 2.
    en_per = 3'b100;
    expect_at("kill1_pre",  143, M_S | M_A, 2'd1, 3'b110, 1'b0, 1'b0);
    expect_at("kill1_act",  144, M_S | M_A | M_M, 2'd1, 3'b100, 1'b0, 1'b0);
    expect_at("kill1_mute", 145, M_S | M_M, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("kill1_hold", 148, M_S | M_M | M_P, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("kill1_sw",   149, M_S | M_M | M_P, 2'd2, 3'b000, 1'b1, 1'b1);
    expect_at("kill1_end",  153, M_S | M_A | M_M, 2'd2, 3'b100, 1'b0, 1'b0);
    step_to(153);

    // Kill channel 2: back to fallback.
    en_per = 3'b000;
    expect_at("kill2_pre",  175, M_S | M_A, 2'd2, 3'b100, 1'b0, 1'b0);
    expect_at("kill2_act",  176, M_A, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("kill2_mute", 177, M_S | M_M, 2'd2, 3'b000, 1'b1, 1'b0);
    expect_at("kill2_sw",   181, M_S | M_P, 2'd0, 3'b000, 1'b1, 1'b1);
    expect_at("kill2_end",  185, M_S | M_M, 2'd0, 3'b000, 1'b0, 1'b0);
    step_to(190);

    // Force to 2 with nothing live.
    force_en  = 1'b1;
    force_sel = 2'd2;
    expect_at("frc2_mute", 191, M_S | M_M, 2'd0, 3'b000, 1'b1, 1'b0);
    expect_at("frc2_hold", 194, M_S, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("frc2_sw",   195, M_S | M_P, 2'd2, 3'b000, 1'b1, 1'b1);
    expect_at("frc2_end",  199, M_S | M_M, 2'd2, 3'b000, 1'b0, 1'b0);
    step_to(200);

    // Out-of-range force index falls back to 0.
    force_sel = 2'd3;
    expect_at("frc3_mute", 201, M_S | M_M, 2'd2, 3'b000, 1'b1, 1'b0);
    expect_at("frc3_hold", 204, M_S, 2'd2, 3'b000, 1'b0, 1'b0);
    expect_at("frc3_sw",   205, M_S | M_P, 2'd0, 3'b000, 1'b1, 1'b1);
    expect_at("frc3_end",  209, M_S | M_M, 2'd0, 3'b000, 1'b0, 1'b0);
    step_to(210);

    // Target change during PRE is deferred to a second sequence.
    force_sel = 2'd1;
    expect_at("defer_mute", 211, M_S | M_M, 2'd0, 3'b000, 1'b1, 1'b0);
    step_to(212);
    force_sel = 2'd2;
    expect_at("defer_sw1",  215, M_S | M_M | M_P, 2'd1, 3'b000, 1'b1, 1'b1);
    expect_at("defer_post", 218, M_S | M_M, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("defer_gap",  219, M_S | M_M | M_P, 2'd1, 3'b000, 1'b0, 1'b0);
    expect_at("defer_mute2", 220, M_S | M_M, 2'd1, 3'b000, 1'b1, 1'b0);
    expect_at("defer_hold", 223, M_S, 2'd1, 3'b000, 1'b0, 1'b0);
    expect_at("defer_sw2",  224, M_S | M_P, 2'd2, 3'b000, 1'b1, 1'b1);
    expect_at("defer_end",  228, M_S | M_M, 2'd2, 3'b000, 1'b0, 1'b0);
    step_to(230);

    // Dropping force reverts to automatic selection.
    force_en = 1'b0;
    expect_at("unfrc_mute", 231, M_S | M_M, 2'd2, 3'b000, 1'b1, 1'b0);
    expect_at("unfrc_sw",   235, M_S | M_P, 2'd0, 3'b000, 1'b1, 1'b1);
    expect_at("unfrc_end",  239, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    step_to(240);

    // Reset in the middle of PRE (timer=2).
    force_en  = 1'b1;
    force_sel = 2'd1;
    en_per    = 3'b010;
    expect_at("midrst_mute", 241, M_S | M_M, 2'd0, 3'b000, 1'b1, 1'b0);
    step_to(242);
    rst_n    = 1'b0;
    force_en = 1'b0;
    expect_at("midrst_now", 242, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("midrst_hold", 243, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("midrst_hold", 244, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("midrst_hold", 245, M_ALL, 2'd0, 3'b000, 1'b0, 1'b0);
    step_to(245);

    // Re-qualification takes two full windows.
    do_release();
    for (int k = 1; k <= 32; k++)
      expect_at("requal_quiet", k, M_S | M_M | M_P, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("requal_w1",   16, M_A, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("requal_pre",  31, M_A, 2'd0, 3'b000, 1'b0, 1'b0);
    expect_at("requal_act",  32, M_A, 2'd0, 3'b010, 1'b0, 1'b0);
    expect_at("requal_mute", 33, M_S | M_M, 2'd0, 3'b000, 1'b1, 1'b0);
    expect_at("requal_sw",   37, M_S | M_P, 2'd1, 3'b000, 1'b1, 1'b1);
    expect_at("requal_end",  41, M_S | M_M, 2'd1, 3'b000, 1'b0, 1'b0);
    step_to(45);

    fin_req = 1'b1;
    wait (mon_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_activity_arbiter.md
# clk_activity_arbiter

- Parametrised N-channel clock-presence detector and source arbiter, running entirely on the local 10 MHz reference clock.
- Each monitored clock domain supplies a slow toggle bit: the MSB of a free-running counter in that domain.
- The block qualifies each channel with windowed edge counting plus acquire/loss hysteresis, then picks the highest-priority live source.
- It drives the BUFGMUX select tree through a mute-bracketed, glitch-safe switch sequence, so downstream logic can hold reset across the change.

## Interface
- N_CH, 2: number of monitored channels (2..8).
- SEL_W, $clog2(N_CH) (min 1): select index width.
- WIN_LOG2, 24: observation window = 2^WIN_LOG2 clk10 cycles.
- EDGE_W, 8: per-channel edge counter width, saturating.
- MIN_EDGES, 4: edges per window required for a pass (1..2^EDGE_W-1).
- ACQ_WIN, 2: consecutive passing windows to declare a channel active.
- LOSS_WIN, 1: consecutive failing windows to declare a channel lost.
- FALLBACK, 0: index selected when nothing is active (local clock).
- MUTE_CYC, 16: cycles of mute before and after the select change (>=1).

Ports:
- clk10  in  1  reference clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- tog_in  in  N_CH  per-channel toggle bits, asynchronous to clk10.
- force_en  in  1  manual override enable (clk10 domain).
- force_sel  in  SEL_W  manual override index.
- sel  out  SEL_W  registered BUFGMUX select index.
- active  out  N_CH  qualified-alive flags, registered.
- mute  out  1  high across the whole switch sequence.
- switch_pulse  out  1  one-cycle strobe in the cycle `sel` changes.

## Operation
- Synchroniser:
  - Per channel: 2-flop synchroniser, then one history flop, all reset to 0.
  - edge = sync XOR history; both rising and falling transitions count.
- Window:
  - WIN_LOG2-bit counter, free-running, wraps.
  - Window end = counter all-ones.
- Edge counter:
  - Increments on edge and saturates at 2^EDGE_W-1.
  - At window end it reloads to the current cycle's edge bit (1 or 0). That edge belongs to the new window.
- Evaluation at window end, per channel:
  - pass = (count including this cycle's edge) >= MIN_EDGES.
  - Pass streak and fail streak counters, each saturating at its threshold.
  - A pass clears the fail streak; a fail clears the pass streak.
  - If active=0 and pass streak reaches ACQ_WIN: active←1.
  - If active=1 and fail streak reaches LOSS_WIN: active←0.
- Target (combinational):
  - If force_en: force_sel, or FALLBACK if force_sel >= N_CH.
  - Else: the lowest index with active=1, or FALLBACK if none.
- FSM states: IDLE, PRE, POST.
  - IDLE:
    - If target != sel: latch target, mute←1, timer←MUTE_CYC-1, go to PRE.
  - PRE:
    - Timer decrements.
    - At 0: sel←latched target, switch_pulse←1 for that one cycle, timer←MUTE_CYC-1, go to POST.
  - POST:
    - Timer decrements.
    - At 0: mute←0, go to IDLE.
- Target changes during PRE/POST are ignored. They are re-evaluated in the first IDLE cycle, so back-to-back sequences are allowed.
- Channel evaluation continues during PRE/POST.

## Timing
- Reset values (asynchronous):
  - sel=FALLBACK, active=0, mute=0, switch_pulse=0, FSM=IDLE.
  - All counters and flops 0.
- tog_in transition to edge visible: 3 clk10 cycles.
- active changes in the cycle after window end.
- active=1 to mute high: 1 cycle when target differs.
- mute rise to sel change: MUTE_CYC cycles.
- sel change to mute fall: MUTE_CYC cycles.
- Total mute width: 2·MUTE_CYC cycles.
- Edge coincident with window end: counts toward the old window's evaluation and also seeds the new window with 1.
- Edge counter saturation: no wrap; counts above the saturation value still pass.
- Reset asserted mid-sequence: mute and sel return to their reset values immediately. Re-qualification starts from zero, taking a minimum of ACQ_WIN full windows.
- force_en toggling: force_en is sampled every IDLE cycle, so deasserting it reverts to automatic selection through a normal sequence.

## Test plan
- Reset (params for all tests: N_CH=3, WIN_LOG2=4, MIN_EDGES=2, ACQ_WIN=2, LOSS_WIN=1, MUTE_CYC=4, FALLBACK=0): hold rst_n low with tog_in toggling. Required: sel=0, active=000, mute=0, switch_pulse=0 throughout.
- Acquire: toggle tog_in[1] every 3 cycles from reset release.
  - active[1]=1 one cycle after the 2nd window end.
  - mute high next cycle.
  - sel=1 with switch_pulse 4 cycles later.
  - mute low 4 cycles after that.
- Loss and threshold: stop tog_in[1] after channel 1 is selected. active[1] clears after one failing window, then sel=0 through an 8-cycle mute. A channel giving exactly 1 edge per window never asserts active.
- Priority: channels 1 and 2 both active gives sel=1. Kill channel 1 and sel becomes 2 via one sequence, not via 0.
- Force: force_en=1, force_sel=2 with all channels idle gives sel=2. force_sel=3 gives sel=0. A target change during PRE is held until POST completes, then a second sequence starts.
- Reset mid-PRE: assert rst_n low at PRE timer=2. mute=0 and sel=0 immediately. After release, no switch occurs before 2 full windows.
